// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM encoding, port indices, the latched command layout and the range check.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Command captured from the winning port when it is granted.
    typedef struct packed {
        logic        we;
        logic        port;
        logic [31:0] a;
        logic [31:0] wd;
    } cmd_t;

    function automatic logic addr_in_range(input logic [31:0] a, input logic [31:0] depth);
        return (a < depth);
    endfunction

endpackage

// File: rtl/dmem_arbiter_chk.sv
// Protocol properties of the arbiter outputs, bound into the top as a passive observer.
// Grants and responses are mutually exclusive and writes only issue from the access phase.
module dmem_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic gnt0,
    input logic gnt1,
    input logic rvalid0,
    input logic rvalid1,
    input logic err0,
    input logic err1,
    input logic mem_we,
    input logic in_access
);

    a_gnt_onehot:   assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (reset) !(rvalid0 && rvalid1));
    a_err0_with_rv: assert property (@(posedge clk) disable iff (reset) err0 |-> rvalid0);
    a_err1_with_rv: assert property (@(posedge clk) disable iff (reset) err1 |-> rvalid1);
    a_we_in_access: assert property (@(posedge clk) disable iff (reset) mem_we |-> in_access);

endmodule

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-input round-robin winner selection; pointer names the port favoured on contention.
// A lone request always wins, whatever the pointer says.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic winner,
    output logic valid
);

    // Pick the winning port from the live requests and the favoured port.
    always_comb begin
        winner = PORT0;
        valid  = req0 | req1;
        if (req0 && req1) begin
            winner = pointer;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-ported data memory: one access every two cycles,
// round-robin on contention, range-checked against DEPTH with an error flag on the response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter logic        RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rd0,
    output logic [31:0] rd1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t      state_r;
    logic        ptr_r;
    cmd_t        cmd_r;
    logic        win_s;
    logic        win_valid_s;
    logic        in_range_s;
    logic [31:0] rd_data_s;
    cmd_t        sel_cmd_s;

    rr_pick2 u_pick (
        .req0    (req0),
        .req1    (req1),
        .pointer (ptr_r),
        .winner  (win_s),
        .valid   (win_valid_s)
    );

    // Gather the winning port's command fields for latching.
    always_comb begin
        sel_cmd_s = '{we: 1'b0, port: PORT0, a: 32'h0, wd: 32'h0};
        if (win_s == PORT1) begin
            sel_cmd_s = '{we: we1, port: PORT1, a: a1, wd: wd1};
        end else begin
            sel_cmd_s = '{we: we0, port: PORT0, a: a0, wd: wd0};
        end
    end

    // Out-of-range reads return zero instead of whatever the memory decodes.
    always_comb begin
        in_range_s = addr_in_range(cmd_r.a, 32'(DEPTH));
        rd_data_s  = 32'h0;
        if (in_range_s) begin
            rd_data_s = mem_rd;
        end else begin
            rd_data_s = 32'h0;
        end
    end

    // Reset is folded in combinationally so an aborted access never writes on the reset edge.
    assign mem_we = (state_r == ST_ACCESS) && cmd_r.we && in_range_s && !reset;
    assign mem_a  = cmd_r.a;
    assign mem_wd = cmd_r.wd;

    // Arbitration FSM with registered grant/response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= RR_INIT;
            cmd_r   <= '{we: 1'b0, port: PORT0, a: 32'h0, wd: 32'h0};
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rd0     <= 32'h0;
            rd1     <= 32'h0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s) begin
                        cmd_r   <= sel_cmd_s;
                        ptr_r   <= ~win_s;
                        state_r <= ST_ACCESS;
                        if (win_s == PORT1) begin
                            gnt1 <= 1'b1;
                        end else begin
                            gnt0 <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_IDLE;
                    if (cmd_r.port == PORT1) begin
                        rvalid1 <= 1'b1;
                        err1    <= ~in_range_s;
                        if (!cmd_r.we) begin
                            rd1 <= rd_data_s;
                        end else begin
                            rd1 <= rd1;
                        end
                    end else begin
                        rvalid0 <= 1'b1;
                        err0    <= ~in_range_s;
                        if (!cmd_r.we) begin
                            rd0 <= rd_data_s;
                        end else begin
                            rd0 <= rd0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_arbiter_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .err0      (err0),
        .err1      (err1),
        .mem_we    (mem_we),
        .in_access (state_r == ST_ACCESS)
    );

endmodule
